// File: rtl/switch_debounce_irq_ctrl.sv
// switch_debounce_irq_ctrl: synchronized, debounced switch inputs with edge-capture interrupt registers
module switch_debounce_irq_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [WIDTH-1:0] meta, sync, stable, irq_mask, edges, done, set, clr;
    logic [1:0] ctrl;
    logic [CW-1:0] cnt [WIDTH];
    logic wr;
    logic unused_wd;
    assign unused_wd = ^writedata;
    assign wr = chipselect & write;
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign done[i] = (sync[i] != stable[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
            always_ff @(posedge clk)
                if (reset)
                    cnt[i] <= '0;
                else
                    cnt[i] <= (sync[i] == stable[i] || done[i]) ? '0 : cnt[i] + 1'b1;
        end
    endgenerate
    always_comb begin
        set = done & ((~stable & {WIDTH{ctrl[0]}}) | (stable & {WIDTH{ctrl[1]}}));
        clr = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            meta     <= '0;
            sync     <= '0;
            stable   <= '0;
            irq_mask <= '0;
            edges    <= '0;
            ctrl     <= 2'b11;
            readdata <= '0;
        end else begin
            meta     <= in_port;
            sync     <= meta;
            stable   <= stable ^ done;
            edges    <= (edges & ~clr) | set;
            irq_mask <= (wr && address == 2'd1) ? writedata[WIDTH-1:0] : irq_mask;
            ctrl     <= (wr && address == 2'd3) ? writedata[1:0] : ctrl;
            readdata <= address == 2'd0 ? 32'(stable) :
                        address == 2'd1 ? 32'(irq_mask) :
                        address == 2'd2 ? 32'(edges) : {30'b0, ctrl};
        end
    end
    assign irq = |(edges & irq_mask);
endmodule

// File: tb/tb_switch_debounce_irq_ctrl.sv
// tb_switch_debounce_irq_ctrl: randomized and directed checks against a sample-history reference model
module tb_switch_debounce_irq_ctrl;
    localparam int W = 4;
    localparam int N = 4;
    logic clk = 0;
    logic reset, chipselect, write;
    logic [1:0] address;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] readdata;
    logic irq;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    switch_debounce_irq_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask
    logic [W-1:0] raw_q[$];
    bit hist[W][$];
    logic [W-1:0] m_stable, m_mask, m_edges, s, flip, m_set, m_clr;
    logic [1:0] m_ctrl;
    logic [31:0] m_rd;
    bit all_diff;
    always @(posedge clk) begin
        if (reset) begin
            raw_q.delete();
            for (int b = 0; b < W; b++) hist[b].delete();
            m_stable = '0;
            m_mask = '0;
            m_edges = '0;
            m_ctrl = 2'b11;
            m_rd = '0;
        end else begin
            m_rd = address == 0 ? 32'(m_stable) : address == 1 ? 32'(m_mask) :
                   address == 2 ? 32'(m_edges) : 32'(m_ctrl);
            s = raw_q.size() >= 2 ? raw_q[raw_q.size()-2] : '0;
            flip = '0;
            for (int b = 0; b < W; b++) begin
                hist[b].push_back(s[b]);
                if (hist[b].size() > N) void'(hist[b].pop_front());
                all_diff = hist[b].size() == N;
                for (int k = 0; k < hist[b].size(); k++)
                    if (hist[b][k] == m_stable[b]) all_diff = 0;
                if (all_diff) begin
                    flip[b] = 1'b1;
                    hist[b].delete();
                end
            end
            m_set = flip & ((~m_stable & {W{m_ctrl[0]}}) | (m_stable & {W{m_ctrl[1]}}));
            m_clr = (chipselect && write && address == 2) ? writedata[W-1:0] : '0;
            m_edges = (m_edges & ~m_clr) | m_set;
            if (chipselect && write && address == 1) m_mask = writedata[W-1:0];
            if (chipselect && write && address == 3) m_ctrl = writedata[1:0];
            m_stable = m_stable ^ flip;
            raw_q.push_back(in_port);
            if (raw_q.size() > 4) void'(raw_q.pop_front());
        end
    end
    task automatic cyc(input logic r, input logic cs, input logic wr, input logic [1:0] a,
                       input logic [31:0] wd, input logic [W-1:0] ip);
        reset = r;
        chipselect = cs;
        write = wr;
        address = a;
        writedata = wd;
        in_port = ip;
        @(negedge clk);
        check("readdata", readdata, m_rd);
        check("irq", {31'b0, irq}, {31'b0, |(m_edges & m_mask)});
    endtask
    initial begin
        logic [W-1:0] ip;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) begin
            cyc(0, 0, 0, 2'(a), 0, 0);
            check("rst_read", readdata, a == 3 ? 32'd3 : 32'd0);
        end
        for (int k = 0; k < 8; k++) cyc(0, 0, 0, 2'(k % 3), 0, 4'b0001);
        cyc(0, 1, 1, 1, 32'hffff_fff1, 4'b0001);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 2, 0, 4'b0001);
        cyc(0, 1, 1, 2, 32'h1, 4'b0001);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 2, 0, 4'b0001);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 4'b0011);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 2'(k % 3), 0, 4'b0001);
        for (int k = 0; k < 8; k++) cyc(0, 0, 0, 2'(k % 3), 0, 4'b0011);
        cyc(0, 1, 1, 3, 32'hffff_fffe, 4'b0011);
        cyc(0, 1, 1, 2, 32'hf, 4'b0011);
        for (int k = 0; k < 8; k++) cyc(0, 0, 0, 2, 0, 4'b0010);
        for (int k = 0; k < 8; k++) cyc(0, 0, 0, 2, 0, 4'b0011);
        cyc(0, 1, 1, 2, 32'hf, 4'b0011);
        for (int k = 0; k < 8; k++) cyc(0, 1, 1, 2, 32'h1, 4'b0010);
        cyc(0, 0, 0, 2, 0, 4'b0010);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 4'b1111);
        cyc(1, 1, 1, 1, 32'hf, 4'b1111);
        for (int k = 0; k < 10; k++) cyc(0, 0, 0, 2'(k % 4), 0, 4'b1111);
        ip = '0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 5) == 0) ip[$urandom_range(0, W-1)] ^= 1'b1;
            cyc($urandom_range(0, 399) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
                2'($urandom), $urandom, ip);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
